// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// fifo_uart_tx_if : read port of the replay FIFO (strobe, data, flag)
// Rev 1.0
// ------------------------------------------------------------------
interface fifo_uart_tx_if;
  logic       read;
  logic [7:0] rdata;
  logic       emptyB;

  // master is the consumer issuing read strobes; slave is the FIFO
  modport master (output read, input rdata, input emptyB);
  modport slave  (input read, output rdata, output emptyB);
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// fifo_uart_tx : drains the replay FIFO and sends each byte as 8N1 UART
// Rev 1.0
// ------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              enable,
  fifo_uart_tx_if.master   fifo,
  output logic             tx,
  output logic             busy,
  output logic             byte_sent,
  output logic [CNT_W-1:0] sent_count
);

  localparam logic [15:0] C_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             read_q, read_d;
  logic             tx_q, tx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [15:0]      baud_q, baud_d;
  logic             byte_sent_q, byte_sent_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             baud_done;

  assign baud_done = (baud_q == C_BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    read_d      = 1'b0;
    tx_d        = tx_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    baud_d      = baud_q;
    byte_sent_d = 1'b0;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && fifo.emptyB) begin
          read_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      // FIFO data is registered: it is valid only in the cycle after the strobe
      LATCH: begin
        shreg_d = fifo.rdata;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_done) begin
          tx_d      = shreg_q[0];
          bit_idx_d = '0;
          baud_d    = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          byte_sent_d = 1'b1;
          count_d     = count_q + 1'b1;
          baud_d      = '0;
          state_d     = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Asynchronous clear forces the line idle-high at once, even mid-bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      read_q      <= 1'b0;
      tx_q        <= 1'b1;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      baud_q      <= '0;
      byte_sent_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      tx_q        <= tx_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      baud_q      <= baud_d;
      byte_sent_q <= byte_sent_d;
      count_q     <= count_d;
    end
  end

  assign fifo.read  = read_q;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign byte_sent  = byte_sent_q;
  assign sent_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fifo_uart_tx : randomized bench; the expected behaviour is a per-cycle
// timeline of {tx, read, byte_sent, busy} built from frame-level timing rules.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int CW  = 4;

  logic          clk    = 1'b0;
  logic          reset  = 1'b0;
  logic          enable = 1'b0;
  logic          tx, busy, byte_sent;
  logic [CW-1:0] sent_count;

  fifo_uart_tx_if ifc ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo       (ifc),
    .tx         (tx),
    .busy       (busy),
    .byte_sent  (byte_sent),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read, rdata is garbage whenever no read was issued
  logic [7:0] fifo_q[$];
  always @(posedge clk) begin
    if (ifc.read && fifo_q.size() != 0) ifc.rdata <= fifo_q.pop_front();
    else                                ifc.rdata <= 8'($urandom);
  end
  always @(negedge clk) ifc.emptyB = (fifo_q.size() != 0);

  int         vecs = 0;
  int         bad  = 0;
  int         exp_sent = 0;
  logic       pend_bs = 1'b0;
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  function automatic void clear_logs();
    got_q.delete();
    exp_q.delete();
    pend_bs = 1'b0;
  endfunction

  function automatic void push_exp(input logic t, input logic r, input logic bz);
    exp_q.push_back({t, r, pend_bs, bz});
    pend_bs = 1'b0;
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) push_exp(1'b1, 1'b0, 1'b0);
  endfunction

  // IDLE, FETCH, LATCH then start, 8 data bits LSB first, stop; pulse follows
  function automatic void add_frame(input logic [7:0] b);
    logic bitv;
    push_exp(1'b1, 1'b0, 1'b0);
    push_exp(1'b1, 1'b1, 1'b1);
    push_exp(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      bitv = 1'b0;
      else if (k == 9) bitv = 1'b1;
      else             bitv = b[k-1];
      for (int c = 0; c < CPB; c++) push_exp(bitv, 1'b0, 1'b1);
    end
    pend_bs = 1'b1;
  endfunction

  function automatic int count_diff(output int first, output logic [3:0] g, output logic [3:0] e);
    int n;
    int len;
    logic [3:0] gi, ei;
    n = 0;
    first = -1;
    g = 'x;
    e = 'x;
    len = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < len; i++) begin
      gi = (i < got_q.size()) ? got_q[i] : 4'bxxxx;
      ei = (i < exp_q.size()) ? exp_q[i] : 4'bxxxx;
      if (gi !== ei) begin
        if (first < 0) begin first = i; g = gi; e = ei; end
        n++;
      end
    end
    return n;
  endfunction

  function automatic int count_pulses();
    int n;
    n = 0;
    foreach (got_q[i]) if (got_q[i][1] === 1'b1) n++;
    return n;
  endfunction

  task automatic tick_log();
    @(negedge clk);
    got_q.push_back({tx, ifc.read, byte_sent, busy});
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_logged(input int n, input int drop_at, input int erase_at, input logic [7:0] erase_byte);
    for (int i = 0; i < n; i++) begin
      tick_log();
      if (i == 0)        enable = 1'b1;
      if (i == drop_at)  enable = 1'b0;
      if (i == erase_at) begin
        fifo_q.delete();
        fifo_q.push_back(erase_byte);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    fifo_q.delete();
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    exp_sent = 0;
    pend_bs  = 1'b0;
  endtask

  task automatic test_reset();
    int nb, fi;
    logic [3:0] g, e;
    repeat (3) @(negedge clk);
    vecs += 5;
    if (tx !== 1'b1)         begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    if (ifc.read !== 1'b0)   begin bad++; $display("FAIL reset_read: got %b expected 0", ifc.read); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (byte_sent !== 1'b0)  begin bad++; $display("FAIL reset_byte_sent: got %b expected 0", byte_sent); end
    if (sent_count !== '0)   begin bad++; $display("FAIL reset_count: got %0d expected 0", sent_count); end
    reset = 1'b1;
    clear_logs();
    add_idle(50);
    run_logged(50, -1, -1, 8'h00);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL empty_timeline: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
    vecs++;
    if (sent_count !== '0) begin bad++; $display("FAIL empty_count: got %0d expected 0", sent_count); end
  endtask

  task automatic test_single();
    int nb, fi;
    logic [3:0] g, e;
    do_reset();
    clear_logs();
    fifo_q.push_back(8'h41);
    add_frame(8'h41);
    add_idle(6);
    exp_sent = (exp_sent + 1) % (1 << CW);
    settle();
    run_logged(exp_q.size(), -1, -1, 8'h00);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL single_timeline: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
    vecs++;
    if (sent_count !== CW'(exp_sent)) begin bad++; $display("FAIL single_count: got %0d expected %0d", sent_count, exp_sent); end
    vecs++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int nb, fi;
    logic [3:0] g, e;
    logic [7:0] bytes[3];
    bytes = '{8'h55, 8'hAA, 8'hFF};
    do_reset();
    clear_logs();
    foreach (bytes[i]) begin
      fifo_q.push_back(bytes[i]);
      add_frame(bytes[i]);
    end
    add_idle(5);
    exp_sent = (exp_sent + 3) % (1 << CW);
    settle();
    run_logged(exp_q.size(), -1, -1, 8'h00);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL b2b_timeline: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
    vecs++;
    if (sent_count !== CW'(exp_sent)) begin bad++; $display("FAIL b2b_count: got %0d expected %0d", sent_count, exp_sent); end
  endtask

  task automatic test_random_stream();
    int nb, fi, n;
    logic [3:0] g, e;
    logic [7:0] b;
    do_reset();
    clear_logs();
    n = $urandom_range(2, 6);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      fifo_q.push_back(b);
      add_frame(b);
    end
    add_idle(5);
    exp_sent = (exp_sent + n) % (1 << CW);
    settle();
    run_logged(exp_q.size(), -1, -1, 8'h00);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL random_timeline: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
    vecs++;
    if (sent_count !== CW'(exp_sent)) begin bad++; $display("FAIL random_count: got %0d expected %0d", sent_count, exp_sent); end
  endtask

  task automatic test_enable_drop();
    int nb, fi;
    logic [3:0] g, e;
    logic [7:0] b0, b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    do_reset();
    clear_logs();
    fifo_q.push_back(b0);
    fifo_q.push_back(b1);
    add_frame(b0);
    add_idle(10);
    exp_sent = (exp_sent + 1) % (1 << CW);
    settle();
    run_logged(exp_q.size(), 3 + CPB + 2, -1, 8'h00);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL drop_timeline: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
    vecs++;
    if (fifo_q.size() != 1) begin bad++; $display("FAIL drop_no_read: fifo holds %0d expected 1", fifo_q.size()); end
    vecs++;
    if (sent_count !== CW'(exp_sent)) begin bad++; $display("FAIL drop_count1: got %0d expected %0d", sent_count, exp_sent); end
    clear_logs();
    add_frame(b1);
    add_idle(5);
    exp_sent = (exp_sent + 1) % (1 << CW);
    run_logged(exp_q.size(), -1, -1, 8'h00);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL resume_timeline: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
    vecs++;
    if (sent_count !== CW'(exp_sent)) begin bad++; $display("FAIL drop_count2: got %0d expected %0d", sent_count, exp_sent); end
  endtask

  task automatic test_replay();
    int nb, fi;
    logic [3:0] g, e;
    logic [7:0] b0, b1, c;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    c  = ~b1;
    do_reset();
    clear_logs();
    fifo_q.push_back(b0);
    fifo_q.push_back(b1);
    add_frame(b0);
    add_frame(c);
    add_idle(4);
    exp_sent = (exp_sent + 2) % (1 << CW);
    settle();
    run_logged(exp_q.size(), -1, 3 + 2 * CPB, c);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL replay_timeline: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
    vecs++;
    if (sent_count !== CW'(exp_sent)) begin bad++; $display("FAIL replay_count: got %0d expected %0d", sent_count, exp_sent); end
  endtask

  task automatic test_reset_mid_frame();
    int nb, fi;
    logic [3:0] g, e;
    do_reset();
    fifo_q.push_back(8'h00);
    settle();
    @(negedge clk);
    enable = 1'b1;
    repeat (3 + CPB + 5) @(negedge clk);
    vecs++;
    if (tx !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL midreset_pre: got tx=%b busy=%b expected tx=0 busy=1", tx, busy); end
    #1 reset = 1'b0;
    #1;
    vecs += 5;
    if (tx !== 1'b1)        begin bad++; $display("FAIL midreset_tx: got %b expected 1", tx); end
    if (ifc.read !== 1'b0)  begin bad++; $display("FAIL midreset_read: got %b expected 0", ifc.read); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (byte_sent !== 1'b0) begin bad++; $display("FAIL midreset_byte_sent: got %b expected 0", byte_sent); end
    if (sent_count !== '0)  begin bad++; $display("FAIL midreset_count: got %0d expected 0", sent_count); end
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    exp_sent = 0;
    clear_logs();
    add_idle(30);
    run_logged(30, -1, -1, 8'h00);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL midreset_after: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
  endtask

  task automatic test_count_wrap();
    int nb, fi, np;
    logic [3:0] g, e;
    logic [7:0] b;
    do_reset();
    clear_logs();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      fifo_q.push_back(b);
      add_frame(b);
    end
    add_idle(4);
    exp_sent = (exp_sent + 17) % (1 << CW);
    settle();
    run_logged(exp_q.size(), -1, -1, 8'h00);
    nb = count_diff(fi, g, e);
    vecs++;
    if (nb != 0) begin bad++; $display("FAIL wrap_timeline: %0d cycles differ, first at %0d got {tx,read,bs,busy}=%b expected %b", nb, fi, g, e); end
    np = count_pulses();
    vecs++;
    if (np != 17) begin bad++; $display("FAIL wrap_pulses: got %0d expected 17", np); end
    vecs++;
    if (sent_count !== CW'(exp_sent)) begin bad++; $display("FAIL wrap_count: got %0d expected %0d", sent_count, exp_sent); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random_stream();
    test_enable_drop();
    test_replay();
    test_reset_mid_frame();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
